seq_timing_decoder: RTL and testbench
=====================================

Name: seq_timing_decoder

Overview:
Parametrised sequence counter and timing/opcode decoder for the basic-computer control unit. It holds the SC register and produces the one-hot timing signals T0..T(2^SC_WIDTH-1). It also registers the decoded opcode lines D0..D(2^OP_WIDTH-1) from the instruction register opcode field. A RUN/HALTED state machine gates the timing outputs so the control logic can stop and restart instruction execution.

Parameters:
SC_WIDTH, 4, sequence-counter width; number of timing lines NT = 2^SC_WIDTH
OP_WIDTH, 3, opcode field width; number of decoded opcode lines ND = 2^OP_WIDTH

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
sc_inc  in  1  increment SC this cycle
sc_clr  in  1  clear SC to 0 this cycle
halt_req  in  1  enter HALTED (e.g. HLT executed)
start  in  1  leave HALTED and restart at T0
op_load  in  1  capture op_in into decoded D register
op_in  in  OP_WIDTH  opcode field from IR
sc_value  out  SC_WIDTH  current SC register value
T  out  NT  one-hot timing signals, T[k]=1 when SC==k and state RUN
D  out  ND  registered one-hot opcode decode
sc_wrap  out  1  one-cycle pulse: SC wrapped from NT-1 to 0
halted  out  1  1 while state is HALTED

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=RUN, sc_value=0, T=1 (T0 asserted), D=0, sc_wrap=0, halted=0.
- States: RUN, HALTED. The state is a register.
  - RUN -> HALTED when halt_req=1.
  - HALTED -> RUN when start=1 and halt_req=0.
  - If start=1 and halt_req=1 in the same cycle: halt_req wins; the block enters or stays in HALTED.
- SC update in RUN, evaluated on each rising edge, priority high to low:
  - halt_req=1: SC holds, the block enters HALTED.
  - sc_clr=1: SC=0.
  - sc_inc=1: SC=SC+1, modulo NT.
  - Otherwise SC holds.
  - sc_clr and sc_inc both 1: clear wins.
- SC in HALTED:
  - SC ignores sc_inc and sc_clr and holds.
  - On the exit edge (start accepted), SC is loaded with 0, so T0 is asserted in the first RUN cycle.
- sc_wrap:
  - Registered. It is 1 in the cycle after an edge where the block is in RUN, halt_req=0, sc_clr=0, sc_inc=1 and SC==NT-1.
  - It is 0 in every other cycle, including clears.
- T timing outputs:
  - Combinational decode of the SC register, zero latency from sc_value.
  - T is all zeros while HALTED.
  - T is exactly one-hot in RUN.
  - No illegal SC values exist because the width is exact.
- D opcode outputs:
  - Registered on op_load=1: D = one-hot(op_in), 1-cycle latency; otherwise D holds.
  - D is independent of state; loading is allowed in HALTED.
  - D is cleared only by reset, never by sc_clr.
- halted: equals (state==HALTED), driven straight from the register.
- Reset mid-operation: asserting rst_n=0 immediately forces all outputs to their reset values regardless of clk. Release is synchronous to the next edge with standard deassertion timing.
- Widths:
  - SC increment arithmetic is SC_WIDTH bits and wraps naturally.
  - NT and ND are computed as 1<<SC_WIDTH and 1<<OP_WIDTH.

Decomposition:
- Shared package (ctrl_pkg):
  - state encoding constants ST_RUN=1'b0, ST_HALTED=1'b1.
  - default widths SC_WIDTH_DEF=4, OP_WIDTH_DEF=3.
- One sub-module, onehot_decoder #(IN_W): purely combinational N-to-2^N one-hot decoder with an enable input (output zero when disabled).
  - Instantiated twice: T uses enable=~halted; D feeds its register with enable=1.

Test Plan:
1. Reset then 16 cycles of sc_inc=1 (defaults) -> T walks 0x0001,0x0002,...,0x8000 then 0x0001; sc_wrap=1 only in the cycle T returns to 0x0001.
2. SC=5, assert sc_clr=1 and sc_inc=1 together -> next cycle sc_value=0, T=0x0001, sc_wrap=0.
3. SC=3, pulse halt_req -> halted=1, T=0x0000, sc_value stays 3 while sc_inc=1 for 4 cycles; pulse start -> halted=0, sc_value=0, T=0x0001.
4. op_in=3'b101, op_load=1 -> next cycle D=0x20; op_in=3'b010 with op_load=0 -> D stays 0x20; sc_clr=1 -> D stays 0x20.
5. In HALTED, assert start=1 and halt_req=1 together -> stays halted=1, T=0x0000; then start alone -> RUN at T0.
6. Mid-count (SC=9, D=0x04), drive rst_n=0 between clock edges -> sc_value=0, T=0x0001, D=0x00, halted=0 immediately, without waiting for a clock edge; parameter sweep SC_WIDTH=3, OP_WIDTH=4 repeats scenarios 1 and 4 with NT=8, ND=16.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-unit sequencing blocks: state encoding and default widths.
package ctrl_pkg;

  localparam logic ST_RUN    = 1'b0;
  localparam logic ST_HALTED = 1'b1;

  localparam int SC_WIDTH_DEF = 4;
  localparam int OP_WIDTH_DEF = 3;

  typedef enum logic {
    RUN    = ST_RUN,
    HALTED = ST_HALTED
  } state_t;

endpackage

// File: rtl/onehot_decoder.sv
// Combinational N-to-2^N one-hot decoder; all outputs low when en is deasserted.
module onehot_decoder #(
  parameter int IN_W = 3
) (
  input  logic [IN_W-1:0]      sel,
  input  logic                 en,
  output logic [(1<<IN_W)-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/seq_timing_decoder.sv
// Sequence counter with one-hot timing decode, registered opcode decode and RUN/HALTED gating.
//
//   state  | meaning
//   RUN    | SC advances/clears under control, T shows one-hot SC
//   HALTED | SC frozen, T forced to zero; start restarts at T0
module seq_timing_decoder
  import ctrl_pkg::*;
#(
  parameter int SC_WIDTH = SC_WIDTH_DEF,
  parameter int OP_WIDTH = OP_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sc_inc,
  input  logic                     sc_clr,
  input  logic                     halt_req,
  input  logic                     start,
  input  logic                     op_load,
  input  logic [OP_WIDTH-1:0]      op_in,
  output logic [SC_WIDTH-1:0]      sc_value,
  output logic [(1<<SC_WIDTH)-1:0] T,
  output logic [(1<<OP_WIDTH)-1:0] D,
  output logic                     sc_wrap,
  output logic                     halted
);

  localparam int ND = 1 << OP_WIDTH;

  state_t          state;
  logic [ND-1:0]   d_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      sc_value <= '0;
      sc_wrap  <= 1'b0;
      D        <= '0;
    end else begin
      sc_wrap <= 1'b0;
      if (op_load) D <= d_next;
      case (state)
        RUN: begin
          if (halt_req) begin
            state <= HALTED;
          end else if (sc_clr) begin
            sc_value <= '0;
          end else if (sc_inc) begin
            sc_value <= sc_value + SC_WIDTH'(1);
            sc_wrap  <= (sc_value == '1);
          end
        end
        HALTED: begin
          // Restart always begins a fresh instruction at T0.
          if (start && !halt_req) begin
            state    <= RUN;
            sc_value <= '0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign halted = (state == HALTED);

  onehot_decoder #(.IN_W(SC_WIDTH)) u_t_dec (
    .sel (sc_value),
    .en  (~halted),
    .y   (T)
  );

  onehot_decoder #(.IN_W(OP_WIDTH)) u_d_dec (
    .sel (op_in),
    .en  (1'b1),
    .y   (d_next)
  );

endmodule

// File: tb/tb_seq_timing_decoder.sv
// Directed plus randomized bench for seq_timing_decoder at default and swept widths.
module tb_seq_timing_decoder;

  logic clk = 1'b0;
  logic rst_n, sc_inc, sc_clr, halt_req, start, op_load;
  logic [2:0]  op_a;
  logic [3:0]  op_b;

  logic [3:0]  sc_a;
  logic [15:0] t_a;
  logic [7:0]  d_a;
  logic        wrap_a, halted_a;

  logic [2:0]  sc_b;
  logic [7:0]  t_b;
  logic [15:0] d_b;
  logic        wrap_b, halted_b;

  int vectors = 0;
  int miscompares = 0;

  int m_sc[2], m_halt[2], m_wrap[2], m_d[2];
  int nt[2] = '{16, 8};

  always #5 clk = ~clk;

  seq_timing_decoder u_a (
    .clk(clk), .rst_n(rst_n), .sc_inc(sc_inc), .sc_clr(sc_clr),
    .halt_req(halt_req), .start(start), .op_load(op_load), .op_in(op_a),
    .sc_value(sc_a), .T(t_a), .D(d_a), .sc_wrap(wrap_a), .halted(halted_a)
  );

  seq_timing_decoder #(.SC_WIDTH(3), .OP_WIDTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .sc_inc(sc_inc), .sc_clr(sc_clr),
    .halt_req(halt_req), .start(start), .op_load(op_load), .op_in(op_b),
    .sc_value(sc_b), .T(t_b), .D(d_b), .sc_wrap(wrap_b), .halted(halted_b)
  );

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sc[i] = 0; m_halt[i] = 0; m_wrap[i] = 0; m_d[i] = 0;
    end
  endtask

  // Behavioural update from the rules, applied once per rising edge.
  task automatic model_edge(input int i, input int op);
    m_wrap[i] = 0;
    if (op_load) m_d[i] = 1 << op;
    if (m_halt[i] == 0) begin
      if (halt_req) m_halt[i] = 1;
      else if (sc_clr) m_sc[i] = 0;
      else if (sc_inc) begin
        m_wrap[i] = (m_sc[i] == nt[i] - 1) ? 1 : 0;
        m_sc[i]   = (m_sc[i] + 1) % nt[i];
      end
    end else if (start && !halt_req) begin
      m_halt[i] = 0;
      m_sc[i]   = 0;
    end
  endtask

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_t(input int i);
    return (m_halt[i] != 0) ? 32'd0 : (32'd1 << m_sc[i]);
  endfunction

  task automatic check_all();
    chk("sc_value", 0, 32'(sc_a), m_sc[0]);
    chk("T",        0, 32'(t_a), exp_t(0));
    chk("D",        0, 32'(d_a), m_d[0]);
    chk("sc_wrap",  0, 32'(wrap_a), m_wrap[0]);
    chk("halted",   0, 32'(halted_a), m_halt[0]);
    chk("sc_value", 1, 32'(sc_b), m_sc[1]);
    chk("T",        1, 32'(t_b), exp_t(1));
    chk("D",        1, 32'(d_b), m_d[1]);
    chk("sc_wrap",  1, 32'(wrap_b), m_wrap[1]);
    chk("halted",   1, 32'(halted_b), m_halt[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, int'(op_a));
    model_edge(1, int'(op_b));
    #1;
    check_all();
  endtask

  task automatic drive(input logic inc, input logic clr, input logic hr, input logic st,
                       input logic ld, input logic [3:0] op);
    sc_inc = inc; sc_clr = clr; halt_req = hr; start = st; op_load = ld;
    op_a = op[2:0]; op_b = op;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 4'd0);
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // full walk through T and wrap back to T0
    drive(1, 0, 0, 0, 0, 4'd0);
    repeat (17) step();

    // clear beats increment
    drive(0, 1, 0, 0, 0, 4'd0); step();
    drive(1, 0, 0, 0, 0, 4'd0); repeat (5) step();
    drive(1, 1, 0, 0, 0, 4'd0); step();

    // halt at SC=3, increments ignored, start resumes at T0
    drive(1, 0, 0, 0, 0, 4'd0); repeat (3) step();
    drive(0, 0, 1, 0, 0, 4'd0); step();
    drive(1, 0, 0, 0, 0, 4'd0); repeat (4) step();
    drive(0, 0, 0, 1, 0, 4'd0); step();
    drive(0, 0, 0, 0, 0, 4'd0); step();

    // opcode load, hold, and immunity to sc_clr
    drive(0, 0, 0, 0, 1, 4'b0101); step();
    drive(0, 0, 0, 0, 0, 4'b0010); step();
    drive(0, 1, 0, 0, 0, 4'b0010); step();
    drive(0, 0, 0, 0, 1, 4'b1101); step();

    // halt_req beats start while halted
    drive(0, 0, 1, 0, 0, 4'd0); step();
    drive(0, 0, 1, 1, 0, 4'd0); repeat (2) step();
    drive(0, 0, 0, 1, 0, 4'd0); step();
    drive(0, 0, 0, 0, 0, 4'd0); step();

    // asynchronous reset mid-count with D loaded
    drive(0, 1, 0, 0, 1, 4'd2); step();
    drive(1, 0, 0, 0, 0, 4'd0); repeat (9) step();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    #2;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 4'd0);
    step();

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
